// File: rtl/fetch_stage_pkg.sv
// Shared encodings for the instruction-fetch stage: FSM states, NOP word, reset PC default.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2,
        ST_READY   = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INST         = '0;
    localparam int unsigned DEFAULT_RESET_PC = 0;
    localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise a bubble is inserted.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              write_en,
    input  logic              load,
    input  logic [DATA_W-1:0] inst_in,
    input  logic [ADDR_W-1:0] pc_plus4_in,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              valid
);

    logic [DATA_W-1:0] inst_q,     inst_d;
    logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;
    logic              valid_q,    valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q     <= DATA_W'(NOP_INST);
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            inst_q     <= inst_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        inst_d     = inst_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush) begin
            inst_d     = DATA_W'(NOP_INST);
            pc_plus4_d = '0;
            valid_d    = 1'b0;
        end else if (!write_en) begin
            inst_d     = inst_q;
            pc_plus4_d = pc_plus4_q;
            valid_d    = valid_q;
        end else if (load) begin
            inst_d     = inst_in;
            pc_plus4_d = pc_plus4_in;
            valid_d    = 1'b1;
        end else begin
            inst_d     = DATA_W'(NOP_INST);
            pc_plus4_d = '0;
            valid_d    = 1'b0;
        end
    end

    assign inst     = inst_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks req/ack to a variable-latency imem,
// buffers one early word and feeds the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_write,
    input  logic              IF_ID_write,
    input  logic              IF_ID_flush,
    input  logic              pc_src,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              pc_jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] IF_ID_inst,
    output logic [ADDR_W-1:0] IF_ID_pc_plus4,
    output logic              IF_ID_valid,
    output logic              fetch_stall
);

    fetch_state_e      state_q,     state_d;
    logic [ADDR_W-1:0] pc_q,        pc_d;
    logic [DATA_W-1:0] buf_q,       buf_d;
    logic [ADDR_W-1:0] redir_tgt_q, redir_tgt_d;

    logic              adv;
    logic              redir;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] pc_plus4;
    logic              ifid_load;
    logic [DATA_W-1:0] ifid_inst;

    assign adv      = pc_write & IF_ID_write;
    assign redir    = pc_write & (pc_jump | pc_src);
    assign tgt      = pc_jump ? jump_target : branch_target;
    assign pc_plus4 = pc_q + ADDR_W'(PC_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            buf_q       <= '0;
            redir_tgt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_q       <= buf_d;
            redir_tgt_q <= redir_tgt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_d       = buf_q;
        redir_tgt_d = redir_tgt_q;
        ifid_load   = 1'b0;
        ifid_inst   = imem_rdata;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    if (redir) begin
                        pc_d = tgt;
                    end else if (adv) begin
                        ifid_load = 1'b1;
                        pc_d      = pc_plus4;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = ST_READY;
                    end
                end else if (redir) begin
                    redir_tgt_d = tgt;
                    state_d     = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                // The request for the old pc must complete before the new address is driven.
                if (redir) begin
                    redir_tgt_d = tgt;
                end
                if (imem_ack) begin
                    pc_d    = redir ? tgt : redir_tgt_q;
                    state_d = ST_FETCH;
                end
            end
            ST_READY: begin
                if (redir) begin
                    pc_d    = tgt;
                    state_d = ST_FETCH;
                end else if (adv) begin
                    ifid_load = 1'b1;
                    ifid_inst = buf_q;
                    pc_d      = pc_plus4;
                    state_d   = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        fetch_stall = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                imem_req    = 1'b0;
                fetch_stall = 1'b1;
            end
            ST_FETCH: begin
                imem_req    = 1'b1;
                fetch_stall = ~imem_ack;
            end
            ST_DISCARD: begin
                imem_req    = 1'b1;
                fetch_stall = 1'b1;
            end
            ST_READY: begin
                imem_req    = 1'b0;
                fetch_stall = 1'b0;
            end
            default: begin
                imem_req    = 1'b0;
                fetch_stall = 1'b1;
            end
        endcase
    end

    assign imem_addr = pc_q;

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .flush       (IF_ID_flush),
        .write_en    (IF_ID_write),
        .load        (ifid_load),
        .inst_in     (ifid_inst),
        .pc_plus4_in (pc_plus4),
        .inst        (IF_ID_inst),
        .pc_plus4    (IF_ID_pc_plus4),
        .valid       (IF_ID_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: variable-latency imem model, transaction-level
// reference model feeding a scoreboard, decoupled monitor.
module tb_fetch_stage;

    localparam int unsigned       ADDR_W = 32;
    localparam int unsigned       DATA_W = 32;
    localparam logic [ADDR_W-1:0] RPC    = 32'h0;

    logic              clk;
    logic              rst;
    logic              pc_write;
    logic              IF_ID_write;
    logic              IF_ID_flush;
    logic              pc_src;
    logic [ADDR_W-1:0] branch_target;
    logic              pc_jump;
    logic [ADDR_W-1:0] jump_target;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] IF_ID_inst;
    logic [ADDR_W-1:0] IF_ID_pc_plus4;
    logic              IF_ID_valid;
    logic              fetch_stall;

    fetch_stage #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (RPC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_write       (pc_write),
        .IF_ID_write    (IF_ID_write),
        .IF_ID_flush    (IF_ID_flush),
        .pc_src         (pc_src),
        .branch_target  (branch_target),
        .pc_jump        (pc_jump),
        .jump_target    (jump_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .IF_ID_inst     (IF_ID_inst),
        .IF_ID_pc_plus4 (IF_ID_pc_plus4),
        .IF_ID_valid    (IF_ID_valid),
        .fetch_stall    (fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE0000 ^ {a[15:0], a[31:16]};
    endfunction

    // Instruction memory: each request is acknowledged after a random 0..lat_max extra cycles.
    int unsigned mem_cnt;
    int unsigned mem_lat;
    int unsigned lat_max;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_cnt <= 0;
            mem_lat <= 0;
        end else if (imem_req) begin
            if (imem_ack) begin
                mem_cnt <= 0;
                mem_lat <= $urandom_range(lat_max, 0);
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    assign imem_ack   = imem_req && (mem_cnt >= mem_lat);
    assign imem_rdata = memf(imem_addr);

    typedef struct {
        logic        stall;
        logic        req;
        logic        chk_addr;
        logic [31:0] addr;
    } now_t;

    typedef struct {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        chk_pc4;
    } ifid_t;

    now_t  q_now[$];
    ifid_t q_ifid[$];

    int compared   = 0;
    int mismatched = 0;
    bit mon_en     = 0;
    bit rnd_ctrl   = 0;

    // Reference model: L is the address the next delivered instruction must come from.
    logic [31:0] L;
    bit          idle;
    bit          held;
    bit          stale;
    ifid_t       cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick_tgt();
        case ($urandom % 4)
            0:       return 32'h0000_0040;
            1:       return 32'h0000_0100;
            2:       return 32'hFFFF_FFF8;
            default: return $urandom & 32'h0000_FFFC;
        endcase
    endfunction

    task automatic model_reset();
        L     = RPC;
        idle  = 1;
        held  = 0;
        stale = 0;
        cur   = '{valid: 0, inst: 0, pc4: 0, chk_pc4: 1};
    endtask

    task automatic do_cycle();
        bit          pw, iw, fl, src, jmp;
        bit          req_e, ackv, useful, avail, redir, adv, deliver;
        logic [31:0] tgt;
        if (rnd_ctrl) begin
            pw  = ($urandom % 100) < 80;
            iw  = ($urandom % 100) < 80;
            fl  = ($urandom % 100) < 8;
            src = ($urandom % 100) < 12;
            jmp = ($urandom % 100) < 8;
        end else begin
            pw = 1; iw = 1; fl = 0; src = 0; jmp = 0;
        end
        pc_write      = pw;
        IF_ID_write   = iw;
        IF_ID_flush   = fl;
        pc_src        = src;
        pc_jump       = jmp;
        branch_target = pick_tgt();
        jump_target   = pick_tgt();
        #2;
        req_e   = !idle && !held;
        ackv    = imem_ack;
        useful  = req_e && ackv && !stale;
        avail   = held || useful;
        redir   = !idle && pw && (jmp || src);
        tgt     = jmp ? jump_target : branch_target;
        adv     = pw && iw;
        deliver = avail && adv && !redir;
        q_now.push_back('{stall: !avail, req: req_e, chk_addr: req_e && !stale, addr: L});
        if (fl)
            cur = '{valid: 0, inst: 0, pc4: 0, chk_pc4: 1};
        else if (iw) begin
            if (deliver)
                cur = '{valid: 1, inst: memf(L), pc4: L + 32'd4, chk_pc4: 1};
            else
                cur = '{valid: 0, inst: 0, pc4: 0, chk_pc4: 0};
        end
        q_ifid.push_back(cur);
        if (idle) begin
            idle = 0;
        end else if (redir) begin
            // A redirect with a fetch still outstanding makes that fetch's data worthless.
            stale = req_e && !ackv;
            held  = 0;
            L     = tgt;
        end else if (stale && ackv) begin
            stale = 0;
        end else if (deliver) begin
            held = 0;
            L    = L + 32'd4;
        end else if (useful) begin
            held = 1;
        end
        @(negedge clk);
    endtask

    always begin
        @(negedge clk);
        #3;
        if (mon_en && q_now.size() > 0) begin
            now_t n;
            n = q_now.pop_front();
            chk("fetch_stall", 32'(fetch_stall), 32'(n.stall));
            chk("imem_req", 32'(imem_req), 32'(n.req));
            if (n.chk_addr)
                chk("imem_addr", imem_addr, n.addr);
        end
        if (mon_en && q_ifid.size() > 1) begin
            ifid_t e;
            e = q_ifid.pop_front();
            chk("IF_ID_valid", 32'(IF_ID_valid), 32'(e.valid));
            chk("IF_ID_inst", IF_ID_inst, e.inst);
            if (e.chk_pc4)
                chk("IF_ID_pc_plus4", IF_ID_pc_plus4, e.pc4);
        end
    end

    // Called on a negedge; checks reset values before any clock edge, releases on a later negedge.
    task automatic apply_reset();
        mon_en = 0;
        #1;
        rst = 1;
        #1;
        chk("rst imem_req", 32'(imem_req), 32'd0);
        chk("rst imem_addr", imem_addr, RPC);
        chk("rst IF_ID_valid", 32'(IF_ID_valid), 32'd0);
        chk("rst IF_ID_inst", IF_ID_inst, 32'd0);
        chk("rst IF_ID_pc_plus4", IF_ID_pc_plus4, 32'd0);
        chk("rst fetch_stall", 32'(fetch_stall), 32'd1);
        q_now.delete();
        q_ifid.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        mon_en = 1;
    endtask

    initial begin
        rst           = 1;
        pc_write      = 0;
        IF_ID_write   = 0;
        IF_ID_flush   = 0;
        pc_src        = 0;
        pc_jump       = 0;
        branch_target = '0;
        jump_target   = '0;
        lat_max       = 0;
        model_reset();
        @(negedge clk);
        apply_reset();

        rnd_ctrl = 0;
        lat_max  = 0;
        for (int i = 0; i < 20; i++) do_cycle();

        lat_max = 3;
        for (int i = 0; i < 30; i++) do_cycle();

        rnd_ctrl = 1;
        for (int i = 0; i < 1500; i++) do_cycle();

        begin
            int guard;
            guard = 0;
            while (!stale && guard < 500) begin
                do_cycle();
                guard++;
            end
            compared++;
            if (!stale) begin
                mismatched++;
                $display("FAIL discard_reach: got stale=%0d expected 1 within %0d cycles", stale, guard);
            end
        end
        apply_reset();

        for (int i = 0; i < 1000; i++) do_cycle();

        rnd_ctrl = 0;
        for (int i = 0; i < 20; i++) do_cycle();

        #4;
        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
